// File: rtl/id_module_if.sv
// ID-stage bus: the fetch-side PC/instruction pair with the freeze/flush
// handshake, plus the ID/EXE pipeline-register bundle.
// master: the decode stage (id_module). slave: the fetch/execute side.
interface id_module_if;
    logic        flush;
    logic [31:0] PC_in;
    logic [31:0] Instruction_in;
    logic        freeze;

    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic [3:0]  EXE_CMD;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic        B;
    logic        S;
    logic        I;
    logic [3:0]  Src1;
    logic [3:0]  Src2;

    modport master (
        input  flush, PC_in, Instruction_in,
        output freeze, PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, Dest,
               EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S, I, Src1, Src2
    );

    modport slave (
        output flush, PC_in, Instruction_in,
        input  freeze, PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, Dest,
               EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S, I, Src1, Src2
    );
endinterface

// File: rtl/id_module.sv
// Instruction-decode stage of the 5-stage ARM pipeline: register file,
// decoder, condition checker, hazard detector and ID/EXE register.
// Optional build macro FORWARDING_EN: when defined, only load-use hazards
// against the EXE stage stall; otherwise any pending EXE/MEM writeback to a
// used source stalls fetch.
module id_module #(
    parameter int NUM_REGS = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   SR,
    input  logic         WB_WB_EN,
    input  logic [3:0]   WB_Dest,
    input  logic [31:0]  WB_Value,
    input  logic         EXE_WB_EN,
    input  logic         MEM_WB_EN,
    input  logic [3:0]   EXE_Dest,
    input  logic [3:0]   MEM_Dest,
    input  logic         EXE_MEM_R_EN,
    id_module_if.master  bus
);

    localparam logic [3:0] PC_IDX = 4'd15;

    // Instruction fields
    logic [3:0]  cond_s;
    logic [1:0]  mode_s;
    logic        imm_s;
    logic [3:0]  opcode_s;
    logic        s_bit_s;
    logic [3:0]  rn_s;
    logic [3:0]  rd_s;
    logic [3:0]  rm_s;

    assign cond_s   = bus.Instruction_in[31:28];
    assign mode_s   = bus.Instruction_in[27:26];
    assign imm_s    = bus.Instruction_in[25];
    assign opcode_s = bus.Instruction_in[24:21];
    assign s_bit_s  = bus.Instruction_in[20];
    assign rn_s     = bus.Instruction_in[19:16];
    assign rd_s     = bus.Instruction_in[15:12];
    assign rm_s     = bus.Instruction_in[3:0];

    // Register file storage (R15 is the PC and is never stored)
    logic [31:0] regs_r [NUM_REGS];

    // Register-file write port; an index of 15 matches no entry so it is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (WB_WB_EN && (WB_Dest == 4'(i))) begin
                    regs_r[i] <= WB_Value;
                end
            end
        end
    end

    // STR reads its data register through the second port
    logic       is_str_s;
    logic [3:0] src2_s;

    assign is_str_s = (mode_s == 2'b01) && !s_bit_s;
    assign src2_s   = is_str_s ? rd_s : rm_s;

    // Read ports: R15 returns PC, a same-cycle writeback is passed through
    logic [31:0] val_rn_s;
    logic [31:0] val_rm_s;

    // Combinational read ports with write-through
    always_comb begin
        val_rn_s = 32'd0;
        val_rm_s = 32'd0;
        if (rn_s == PC_IDX) begin
            val_rn_s = bus.PC_in;
        end else if (WB_WB_EN && (WB_Dest == rn_s)) begin
            val_rn_s = WB_Value;
        end else begin
            val_rn_s = regs_r[rn_s];
        end
        if (src2_s == PC_IDX) begin
            val_rm_s = bus.PC_in;
        end else if (WB_WB_EN && (WB_Dest == src2_s)) begin
            val_rm_s = WB_Value;
        end else begin
            val_rm_s = regs_r[src2_s];
        end
    end

    // Decoded control
    logic [3:0] exe_cmd_s;
    logic       wb_en_s;
    logic       mem_r_en_s;
    logic       mem_w_en_s;
    logic       b_s;
    logic       s_s;

    // Main decoder: mode/opcode to execute command and control bits
    always_comb begin
        exe_cmd_s  = 4'b0000;
        wb_en_s    = 1'b0;
        mem_r_en_s = 1'b0;
        mem_w_en_s = 1'b0;
        b_s        = 1'b0;
        s_s        = 1'b0;
        case (mode_s)
            2'b00: begin
                wb_en_s = 1'b1;
                s_s     = s_bit_s;
                case (opcode_s)
                    4'b1101: exe_cmd_s = 4'b0001;  // MOV
                    4'b1111: exe_cmd_s = 4'b1001;  // MVN
                    4'b0100: exe_cmd_s = 4'b0010;  // ADD
                    4'b0101: exe_cmd_s = 4'b0011;  // ADC
                    4'b0010: exe_cmd_s = 4'b0100;  // SUB
                    4'b0110: exe_cmd_s = 4'b0101;  // SBC
                    4'b0000: exe_cmd_s = 4'b0110;  // AND
                    4'b1100: exe_cmd_s = 4'b0111;  // ORR
                    4'b0001: exe_cmd_s = 4'b1000;  // EOR
                    4'b1010: begin                 // CMP
                        exe_cmd_s = 4'b0100;
                        wb_en_s   = 1'b0;
                    end
                    4'b1000: begin                 // TST
                        exe_cmd_s = 4'b0110;
                        wb_en_s   = 1'b0;
                    end
                    default: begin                 // unsupported: NOP
                        exe_cmd_s = 4'b0000;
                        wb_en_s   = 1'b0;
                        s_s       = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                exe_cmd_s = 4'b0010;
                if (s_bit_s) begin
                    mem_r_en_s = 1'b1;
                    wb_en_s    = 1'b1;
                end else begin
                    mem_w_en_s = 1'b1;
                end
            end
            2'b10: begin
                b_s = 1'b1;
            end
            default: begin
                b_s = 1'b0;
            end
        endcase
    end

    // Condition check against {N,Z,C,V}
    logic flag_n_s;
    logic flag_z_s;
    logic flag_c_s;
    logic flag_v_s;
    logic cond_ok_s;

    assign {flag_n_s, flag_z_s, flag_c_s, flag_v_s} = SR;

    // Evaluate the instruction's condition field
    always_comb begin
        cond_ok_s = 1'b0;
        case (cond_s)
            4'b0000: cond_ok_s = flag_z_s;
            4'b0001: cond_ok_s = !flag_z_s;
            4'b0010: cond_ok_s = flag_c_s;
            4'b0011: cond_ok_s = !flag_c_s;
            4'b0100: cond_ok_s = flag_n_s;
            4'b0101: cond_ok_s = !flag_n_s;
            4'b0110: cond_ok_s = flag_v_s;
            4'b0111: cond_ok_s = !flag_v_s;
            4'b1000: cond_ok_s = flag_c_s && !flag_z_s;
            4'b1001: cond_ok_s = !flag_c_s || flag_z_s;
            4'b1010: cond_ok_s = (flag_n_s == flag_v_s);
            4'b1011: cond_ok_s = (flag_n_s != flag_v_s);
            4'b1100: cond_ok_s = !flag_z_s && (flag_n_s == flag_v_s);
            4'b1101: cond_ok_s = flag_z_s || (flag_n_s != flag_v_s);
            4'b1110: cond_ok_s = 1'b1;
            default: cond_ok_s = 1'b0;
        endcase
    end

    // Which source ports the instruction actually reads (branches read none)
    logic rn_used_s;
    logic src2_used_s;
    logic exe_hit_s;
    logic mem_hit_s;
    logic freeze_s;

    assign rn_used_s   = (mode_s != 2'b10) &&
                         !((mode_s == 2'b00) && ((opcode_s == 4'b1101) || (opcode_s == 4'b1111)));
    assign src2_used_s = ((mode_s == 2'b00) && !imm_s) || is_str_s;

    assign exe_hit_s = EXE_WB_EN && ((rn_used_s && (rn_s == EXE_Dest)) ||
                                     (src2_used_s && (src2_s == EXE_Dest)));
    assign mem_hit_s = MEM_WB_EN && ((rn_used_s && (rn_s == MEM_Dest)) ||
                                     (src2_used_s && (src2_s == MEM_Dest)));

`ifdef FORWARDING_EN
    // Results reach the sources by forwarding except a load still in EXE
    logic unused_mem_hit_s;
    assign unused_mem_hit_s = mem_hit_s;
    assign freeze_s = exe_hit_s && EXE_MEM_R_EN;
`else
    // Without forwarding the load flag carries no extra information
    logic unused_exe_mem_r_en_s;
    assign unused_exe_mem_r_en_s = EXE_MEM_R_EN;
    assign freeze_s = exe_hit_s || mem_hit_s;
`endif

    assign bus.freeze = freeze_s;

    logic bubble_s;
    assign bubble_s = freeze_s || bus.flush || !cond_ok_s;

    // ID/EXE pipeline register: data always loads, control is squashed on bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.PC            <= 32'd0;
            bus.Val_Rn        <= 32'd0;
            bus.Val_Rm        <= 32'd0;
            bus.Shift_operand <= 12'd0;
            bus.Signed_imm_24 <= 24'd0;
            bus.Dest          <= 4'd0;
            bus.I             <= 1'b0;
            bus.Src1          <= 4'd0;
            bus.Src2          <= 4'd0;
            bus.EXE_CMD       <= 4'd0;
            bus.MEM_R_EN      <= 1'b0;
            bus.MEM_W_EN      <= 1'b0;
            bus.WB_EN         <= 1'b0;
            bus.B             <= 1'b0;
            bus.S             <= 1'b0;
        end else begin
            bus.PC            <= bus.PC_in;
            bus.Val_Rn        <= val_rn_s;
            bus.Val_Rm        <= val_rm_s;
            bus.Shift_operand <= bus.Instruction_in[11:0];
            bus.Signed_imm_24 <= bus.Instruction_in[23:0];
            bus.Dest          <= rd_s;
            bus.I             <= imm_s;
            bus.Src1          <= rn_s;
            bus.Src2          <= src2_s;
            if (bubble_s) begin
                bus.EXE_CMD  <= 4'd0;
                bus.MEM_R_EN <= 1'b0;
                bus.MEM_W_EN <= 1'b0;
                bus.WB_EN    <= 1'b0;
                bus.B        <= 1'b0;
                bus.S        <= 1'b0;
            end else begin
                bus.EXE_CMD  <= exe_cmd_s;
                bus.MEM_R_EN <= mem_r_en_s;
                bus.MEM_W_EN <= mem_w_en_s;
                bus.WB_EN    <= wb_en_s;
                bus.B        <= b_s;
                bus.S        <= s_s;
            end
        end
    end

endmodule

// File: tb/tb_id_module.sv
// Self-checking bench for id_module: a reference decoder pushes the expected
// ID/EXE contents into a queue as each instruction is driven; they are popped
// and compared one cycle later. Honours FORWARDING_EN if defined.
module tb_id_module;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shop;
        logic [23:0] imm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic        i;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SR;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        EXE_WB_EN;
    logic        MEM_WB_EN;
    logic [3:0]  EXE_Dest;
    logic [3:0]  MEM_Dest;
    logic        EXE_MEM_R_EN;

    id_module_if bus ();

    id_module dut (
        .clk          (clk),
        .rst          (rst),
        .SR           (SR),
        .WB_WB_EN     (WB_WB_EN),
        .WB_Dest      (WB_Dest),
        .WB_Value     (WB_Value),
        .EXE_WB_EN    (EXE_WB_EN),
        .MEM_WB_EN    (MEM_WB_EN),
        .EXE_Dest     (EXE_Dest),
        .MEM_Dest     (MEM_Dest),
        .EXE_MEM_R_EN (EXE_MEM_R_EN),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] regs_m [16];
    out_t        sbq [$];
    out_t        exp_o;
    out_t        obs_o;

`ifdef FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    function automatic out_t observe();
        out_t o;
        o.pc = bus.PC;             o.val_rn = bus.Val_Rn;   o.val_rm = bus.Val_Rm;
        o.shop = bus.Shift_operand; o.imm = bus.Signed_imm_24; o.dest = bus.Dest;
        o.cmd = bus.EXE_CMD;       o.mr = bus.MEM_R_EN;     o.mw = bus.MEM_W_EN;
        o.wb = bus.WB_EN;          o.b = bus.B;             o.s = bus.S;
        o.i = bus.I;               o.src1 = bus.Src1;       o.src2 = bus.Src2;
        return o;
    endfunction

    function automatic logic [31:0] ref_read(input logic [3:0] idx);
        if (idx == 4'd15) return bus.PC_in;
        if (WB_WB_EN && (WB_Dest == idx)) return WB_Value;
        return regs_m[idx];
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_freeze();
        logic [31:0] ins;
        logic [1:0]  md;
        logic [3:0]  op, s2;
        logic        str, use_rn, use_s2, ex, mm;
        ins    = bus.Instruction_in;
        md     = ins[27:26];
        op     = ins[24:21];
        str    = (md == 2'b01) && !ins[20];
        s2     = str ? ins[15:12] : ins[3:0];
        use_rn = (md != 2'b10) && !((md == 2'b00) && (op == 4'hD || op == 4'hF));
        use_s2 = ((md == 2'b00) && !ins[25]) || str;
        ex = EXE_WB_EN && ((use_rn && ins[19:16] == EXE_Dest) || (use_s2 && s2 == EXE_Dest));
        mm = MEM_WB_EN && ((use_rn && ins[19:16] == MEM_Dest) || (use_s2 && s2 == MEM_Dest));
        if (FWD) return ex && EXE_MEM_R_EN;
        return ex || mm;
    endfunction

    function automatic out_t ref_expect();
        out_t        e;
        logic [31:0] ins;
        logic [3:0]  s2;
        ins = bus.Instruction_in;
        s2  = (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
        e = '0;
        e.pc = bus.PC_in;
        e.val_rn = ref_read(ins[19:16]);
        e.val_rm = ref_read(s2);
        e.shop = ins[11:0];
        e.imm = ins[23:0];
        e.dest = ins[15:12];
        e.i = ins[25];
        e.src1 = ins[19:16];
        e.src2 = s2;
        if (!ref_freeze() && !bus.flush && ref_cond(ins[31:28], SR)) begin
            case (ins[27:26])
                2'b00: begin
                    e.wb = 1'b1;
                    e.s  = ins[20];
                    case (ins[24:21])
                        4'hD: e.cmd = 4'h1;
                        4'hF: e.cmd = 4'h9;
                        4'h4: e.cmd = 4'h2;
                        4'h5: e.cmd = 4'h3;
                        4'h2: e.cmd = 4'h4;
                        4'h6: e.cmd = 4'h5;
                        4'h0: e.cmd = 4'h6;
                        4'hC: e.cmd = 4'h7;
                        4'h1: e.cmd = 4'h8;
                        4'hA: begin e.cmd = 4'h4; e.wb = 1'b0; end
                        4'h8: begin e.cmd = 4'h6; e.wb = 1'b0; end
                        default: begin e.wb = 1'b0; e.s = 1'b0; end
                    endcase
                end
                2'b01: begin
                    e.cmd = 4'h2;
                    e.mr  = ins[20];
                    e.wb  = ins[20];
                    e.mw  = !ins[20];
                end
                2'b10: e.b = 1'b1;
                default: e.b = 1'b0;
            endcase
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst && WB_WB_EN && WB_Dest != 4'd15) regs_m[WB_Dest] = WB_Value;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; SR = 4'd0; WB_WB_EN = 1'b0; WB_Dest = 4'd0; WB_Value = 32'd0;
        EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0; EXE_Dest = 4'd0; MEM_Dest = 4'd0;
        EXE_MEM_R_EN = 1'b0; bus.flush = 1'b0; bus.PC_in = 32'd0; bus.Instruction_in = 32'd0;
        for (int i = 0; i < 16; i++) regs_m[i] = 32'd0;
        repeat (3) tick();
        obs_o = observe();
        n_checks++;
        if (obs_o !== out_t'(0)) begin
            n_errors++; $display("FAIL reset_outputs got=%h want=0", obs_o);
        end
        n_checks++;
        if (bus.freeze !== 1'b0) begin
            n_errors++; $display("FAIL reset_freeze got=%b want=0", bus.freeze);
        end
        rst = 1'b1;
        for (int r = 0; r < 15; r++) begin
            bus.PC_in = 32'h1000 + 32'(r);
            bus.Instruction_in = 32'hE0800000 | (32'(r) << 16) | 32'(r);
            #1;
            sbq.push_back(ref_expect());
            tick();
            obs_o = observe(); exp_o = sbq.pop_front();
            n_checks++;
            if (obs_o !== exp_o || obs_o.val_rn !== 32'd0 || obs_o.val_rm !== 32'd0) begin
                n_errors++; $display("FAIL reset_read_r%0d got=%h want=%h", r, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_wb_bypass();
        logic [31:0] ins_t [3] = '{32'hE0812003, 32'hE0812003, 32'hE08F0001};
        logic        wen_t [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0]  wd_t  [3] = '{4'd3, 4'd3, 4'd15};
        for (int k = 0; k < 3; k++) begin
            WB_WB_EN = wen_t[k]; WB_Dest = wd_t[k]; WB_Value = 32'hDEADBEEF;
            bus.PC_in = 32'h0000_0100; bus.Instruction_in = ins_t[k];
            #1;
            sbq.push_back(ref_expect());
            tick();
            obs_o = observe(); exp_o = sbq.pop_front();
            n_checks++;
            if (obs_o !== exp_o) begin
                n_errors++; $display("FAIL wb_bypass_%0d got=%h want=%h", k, obs_o, exp_o);
            end
            n_checks++;
            if (k < 2 && (obs_o.val_rm !== 32'hDEADBEEF || obs_o.cmd !== 4'b0010 ||
                          obs_o.wb !== 1'b1 || obs_o.dest !== 4'd2)) begin
                n_errors++; $display("FAIL wb_bypass_fields_%0d got=%h", k, obs_o);
            end else if (k == 2 && obs_o.val_rn !== 32'h0000_0100) begin
                n_errors++; $display("FAIL r15_reads_pc got=%h want=00000100", obs_o.val_rn);
            end
        end
        WB_WB_EN = 1'b0;
    endtask

    task automatic test_cond();
        SR = 4'b0000; bus.Instruction_in = 32'h03A01005; #1;
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || obs_o.wb !== 1'b0 || obs_o.cmd !== 4'b0000) begin
            n_errors++; $display("FAIL cond_fail got=%h want=%h", obs_o, exp_o);
        end
        SR = 4'b0100; #1;
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || obs_o.cmd !== 4'b0001 || obs_o.wb !== 1'b1 ||
            obs_o.i !== 1'b1 || obs_o.shop !== 12'h005) begin
            n_errors++; $display("FAIL cond_pass got=%h want=%h", obs_o, exp_o);
        end
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f += 5) begin
                SR = 4'(f);
                bus.Instruction_in = {4'(c), 28'h3A01005};
                #1;
                sbq.push_back(ref_expect());
                tick();
                obs_o = observe(); exp_o = sbq.pop_front();
                n_checks++;
                if (obs_o !== exp_o) begin
                    n_errors++; $display("FAIL cond_%0d_sr%0d got=%h want=%h", c, f, obs_o, exp_o);
                end
            end
        end
        SR = 4'b0000;
    endtask

    task automatic test_hazard();
        // instr, exe_dest, exe_wb, mem_dest, mem_wb, exe_mem_r, freeze(no fwd), freeze(fwd)
        logic [31:0] ins_t [7] = '{32'hE0812003, 32'hE0812003, 32'hE0812003, 32'hE0812003,
                                   32'hE1A12003, 32'hE2812003, 32'hE1A12003};
        logic [3:0]  ed_t  [7] = '{4'd1, 4'd1, 4'd0, 4'd3, 4'd1, 4'd3, 4'd3};
        logic        ew_t  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0]  md_t  [7] = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        logic        mw_t  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        lr_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        fn_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ff_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        want;
        for (int k = 0; k < 7; k++) begin
            bus.Instruction_in = ins_t[k];
            EXE_Dest = ed_t[k]; EXE_WB_EN = ew_t[k]; MEM_Dest = md_t[k];
            MEM_WB_EN = mw_t[k]; EXE_MEM_R_EN = lr_t[k];
            want = FWD ? ff_t[k] : fn_t[k];
            #1;
            n_checks++;
            if (bus.freeze !== want) begin
                n_errors++; $display("FAIL hazard_freeze_%0d got=%b want=%b", k, bus.freeze, want);
            end
            sbq.push_back(ref_expect());
            tick();
            obs_o = observe(); exp_o = sbq.pop_front();
            n_checks++;
            if (obs_o !== exp_o || (want && obs_o.wb !== 1'b0)) begin
                n_errors++; $display("FAIL hazard_out_%0d got=%h want=%h", k, obs_o, exp_o);
            end
        end
        EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
    endtask

    task automatic test_str();
        bus.Instruction_in = 32'hE5812000; MEM_Dest = 4'd2; MEM_WB_EN = 1'b1; #1;
        n_checks++;
        if (bus.freeze !== !FWD) begin
            n_errors++; $display("FAIL str_freeze got=%b want=%b", bus.freeze, !FWD);
        end
        sbq.push_back(ref_expect());
        tick();
        exp_o = sbq.pop_front();
        MEM_WB_EN = 1'b0; #1;
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || obs_o.mw !== 1'b1 || obs_o.src2 !== 4'd2 || obs_o.wb !== 1'b0) begin
            n_errors++; $display("FAIL str_clear got=%h want=%h", obs_o, exp_o);
        end
        bus.Instruction_in = 32'hE5912000; #1;
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || obs_o.mr !== 1'b1 || obs_o.wb !== 1'b1 || obs_o.src2 !== 4'd0) begin
            n_errors++; $display("FAIL ldr got=%h want=%h", obs_o, exp_o);
        end
    endtask

    task automatic test_branch();
        bus.Instruction_in = 32'hEAFFFFFE; bus.flush = 1'b0;
        EXE_Dest = 4'd14; EXE_WB_EN = 1'b1; MEM_Dest = 4'd15; MEM_WB_EN = 1'b1;
        EXE_MEM_R_EN = 1'b1; #1;
        n_checks++;
        if (bus.freeze !== 1'b0) begin
            n_errors++; $display("FAIL branch_nostall got=%b want=0", bus.freeze);
        end
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || obs_o.b !== 1'b1 || obs_o.imm !== 24'hFFFFFE) begin
            n_errors++; $display("FAIL branch got=%h want=%h", obs_o, exp_o);
        end
        bus.flush = 1'b1; #1;
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || {obs_o.cmd, obs_o.mr, obs_o.mw, obs_o.wb, obs_o.b, obs_o.s} !== 9'd0) begin
            n_errors++; $display("FAIL branch_flush got=%h want=%h", obs_o, exp_o);
        end
        bus.Instruction_in = 32'hE0812003; EXE_Dest = 4'd1; #1;
        n_checks++;
        if (bus.freeze !== 1'b1) begin
            n_errors++; $display("FAIL flush_freeze got=%b want=1", bus.freeze);
        end
        sbq.push_back(ref_expect());
        tick();
        obs_o = observe(); exp_o = sbq.pop_front();
        n_checks++;
        if (obs_o !== exp_o || {obs_o.cmd, obs_o.wb} !== 5'd0) begin
            n_errors++; $display("FAIL flush_freeze_out got=%h want=%h", obs_o, exp_o);
        end
        bus.flush = 1'b0; EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic        want;
        for (int n = 0; n < 200; n++) begin
            ins = $urandom();
            ins[27:26] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            bus.Instruction_in = ins;
            bus.PC_in = $urandom();
            SR = 4'($urandom_range(0, 15));
            bus.flush = ($urandom_range(0, 7) == 0);
            WB_WB_EN = ($urandom_range(0, 1) == 0);
            WB_Dest = 4'($urandom_range(0, 15));
            WB_Value = $urandom();
            EXE_WB_EN = ($urandom_range(0, 3) == 0);
            EXE_Dest = 4'($urandom_range(0, 15));
            MEM_WB_EN = ($urandom_range(0, 3) == 0);
            MEM_Dest = 4'($urandom_range(0, 15));
            EXE_MEM_R_EN = ($urandom_range(0, 1) == 0);
            #1;
            want = ref_freeze();
            n_checks++;
            if (bus.freeze !== want) begin
                n_errors++; $display("FAIL b2b_freeze_%0d got=%b want=%b", n, bus.freeze, want);
            end
            sbq.push_back(ref_expect());
            tick();
            obs_o = observe(); exp_o = sbq.pop_front();
            n_checks++;
            if (obs_o !== exp_o) begin
                n_errors++; $display("FAIL b2b_%0d ins=%h got=%h want=%h", n, ins, obs_o, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_cond();
        test_hazard();
        test_str();
        test_branch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
